vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Shares a single-port synchronous framebuffer RAM between three users: display scan-out, a full-screen clear engine, and a pixel writer. It sits between the VGA timing generator and the colour outputs, and replaces a fixed test-pattern source with memory-backed pixels. Display fetches always win arbitration. The writer is decoupled by a one-entry buffer. Colour and sync outputs are realigned so that they leave the block together.

## Interface
- FB_W, 160: framebuffer width in pixels
- FB_H, 120: framebuffer height in pixels
- SCALE_SHIFT, 2: log2 of the screen-to-framebuffer pixel scale (2 gives 4x4 blocks)
- DATA_W, 12: pixel width, laid out as {r[3:0], g[3:0], b[3:0]}
- ADDR_W, 15: RAM address width
- clk_i  in  1  pixel clock (25 MHz); single clock domain
- rst_ni  in  1  asynchronous, active-low reset
- disp_active_i  in  1  timing generator: visible region
- xcol_i, yrow_i  in  10 each  timing generator: current pixel
- hsync_i, vsync_i  in  1 each  timing generator syncs
- hsync_o, vsync_o  out  1 each  syncs delayed by 2 cycles
- color_o  out  DATA_W  pixel colour; 0 outside the visible region
- wr_valid_i, wr_ready_o  in/out  1 each  writer handshake
- wr_x_i  in  8  writer x coordinate
- wr_y_i  in  7  writer y coordinate
- wr_data_i  in  DATA_W  writer pixel value
- clr_i  in  1  pulse: start a clear
- clr_color_i  in  DATA_W  clear colour, sampled on the accepted `clr_i`
- busy_o  out  1  clear in progress
- drop_o  out  1  sticky: an out-of-range write was dropped
- drop_clr_i  in  1  clears `drop_o`
- mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o  out  RAM port (combinational from the current cycle's arbitration)
- mem_rdata_i  in  DATA_W  RAM read data; valid 1 cycle after a read

## Operation
- Addresses: addr = y*FB_W + x. For the display, x = xcol_i>>SCALE_SHIFT and y = yrow_i>>SCALE_SHIFT.
- Display fetch (`dfetch`): asserted when disp_active_i is high and xcol_i[SCALE_SHIFT-1:0] == 0.
- Per-cycle grant priority:
  1. `dfetch`: read.
  2. Clear engine (state CLEAR): write.
  3. Write buffer full and state IDLE: write.
  4. Otherwise mem_en_o is 0.
- Write buffer: one entry.
  - wr_ready_o is low when the buffer is full or state is CLEAR.
  - Accept condition: wr_valid_i && wr_ready_o.
  - Out-of-range coordinates (x ≥ FB_W or y ≥ FB_H): the write is accepted, not stored, and drop_o is set.
  - The entry drains on its grant cycle. A new write may be accepted in the same cycle the buffer drains.
- FSM states: IDLE and CLEAR.
  - IDLE→CLEAR on clr_i. The counter loads 0 and the colour is latched. Any buffered write is discarded.
  - The counter advances only on CLEAR grant cycles.
  - CLEAR→IDLE after address FB_W*FB_H-1 is written.
  - clr_i while in CLEAR is ignored.
- busy_o is high while the state is CLEAR.
- drop_clr_i and a new drop in the same cycle: drop_o stays set (the set wins).

## Timing
- Display latency is 2 cycles. color_o at cycle t+2 corresponds to the (xcol, yrow, disp_active) presented at cycle t.
- Pixel hold: a fetch at t is issued, mem_rdata_i is captured into color_o at the end of t+1, and that value is held for the next 2^SCALE_SHIFT−1 pixels.
- When active is delayed by 2 cycles and is low, color_o is 0.
- hsync_o and vsync_o pass through a 2-stage register, so they stay aligned with color_o.
- Reset values:
  - color_o = 0.
  - hsync_o = vsync_o = 1 (inactive).
  - wr_ready_o = 1, busy_o = 0, drop_o = 0.
  - State IDLE; buffer empty; counter 0.
- Bandwidth:
  - During active video, the writer and clear engine get ≥ 3 of every 4 cycles.
  - During blanking they get every cycle.
  - A clear takes ≥ 19200 cycles.
- Reset during CLEAR aborts immediately; RAM contents stay partial.

## Structure
- Package `vga_pkg` holds:
  - FB_W, FB_H, and the derived FB_SIZE.
  - The colour field slices.
  - The FSM enum {IDLE, CLEAR}.
- Sub-module `vga_fb_wbuf`: the one-entry write buffer, including the range check and drop flag.
- The arbitration, clear FSM, and output alignment stay in the top module.

## Test plan
- Reset: hold rst_ni low mid-frame → color_o=0, hsync_o=vsync_o=1, wr_ready_o=1, busy_o=0.
- Preload RAM[0]=12'hF00 and RAM[1]=12'h0F0; scan row 0 → color_o=F00 for 4 pixels, then 0F0 for 4 pixels, starting 2 cycles after xcol=0; hsync_o is aligned with it.
- Write (x=5, y=3, 12'h00F) while xcol=20 is active → write is stalled exactly on the dfetch cycle; mem_addr_o=485 on the write grant.
- clr_i with clr_color_i=12'hABC, free-running timing → busy_o is high until 19200 writes; RAM is all ABC; wr_ready_o is low throughout the clear.
- Write x=160, y=0 → handshake completes, no RAM write occurs, drop_o=1; pulse drop_clr_i → drop_o=0.
- clr_i while the buffer is full and active video is running → buffered write is discarded; a second clr_i during the clear is ignored; the display is never starved.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared framebuffer geometry, pixel layout and arbiter FSM states
`timescale 1ns/1ps
package vga_pkg;
  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 15;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  typedef enum logic {IDLE, CLEAR} fsm_state_t;
endpackage

// File: rtl/vga_fb_wbuf.sv
// rtl/vga_fb_wbuf.sv - one-entry pixel write buffer with range check and sticky drop flag
`timescale 1ns/1ps
module vga_fb_wbuf #(
  parameter int FB_W   = vga_pkg::FB_W,
  parameter int FB_H   = vga_pkg::FB_H,
  parameter int DATA_W = vga_pkg::DATA_W,
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [7:0]        wr_x_i,
  input  logic [6:0]        wr_y_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              block_i,
  input  logic              flush_i,
  input  logic              drain_i,
  output logic              full_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              drop_clr_i,
  output logic              drop_o
);
  logic accept;
  logic in_range;

  // A draining entry frees the slot in the same cycle, so back-to-back writes stream.
  assign wr_ready_o = (!full_o || drain_i) && !block_i;
  assign accept     = wr_valid_i && wr_ready_o;
  assign in_range   = (32'(wr_x_i) < 32'(FB_W)) && (32'(wr_y_i) < 32'(FB_H));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_o <= 1'b0;
      addr_o <= '0;
      data_o <= '0;
      drop_o <= 1'b0;
    end else begin
      if (flush_i)                full_o <= 1'b0;
      else if (accept && in_range) full_o <= 1'b1;
      else if (drain_i)           full_o <= 1'b0;

      if (accept && in_range) begin
        addr_o <= ADDR_W'(32'(wr_y_i) * 32'(FB_W) + 32'(wr_x_i));
        data_o <= wr_data_i;
      end

      if (accept && !in_range) drop_o <= 1'b1;
      else if (drop_clr_i)     drop_o <= 1'b0;
    end
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter: display scan-out, clear engine and pixel writer
`timescale 1ns/1ps
module vga_fb_arbiter #(
  parameter int FB_W        = vga_pkg::FB_W,
  parameter int FB_H        = vga_pkg::FB_H,
  parameter int SCALE_SHIFT = 2,
  parameter int DATA_W      = vga_pkg::DATA_W,
  parameter int ADDR_W      = vga_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              disp_active_i,
  input  logic [9:0]        xcol_i,
  input  logic [9:0]        yrow_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic [DATA_W-1:0] color_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [7:0]        wr_x_i,
  input  logic [6:0]        wr_y_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] clr_color_i,
  output logic              busy_o,
  output logic              drop_o,
  input  logic              drop_clr_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  import vga_pkg::*;

  localparam int FB_CNT = FB_W * FB_H;

  fsm_state_t        state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] clr_col;
  logic              dfetch, clr_start, clr_gnt, wr_gnt;
  logic [ADDR_W-1:0] disp_addr;
  logic              buf_full;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [1:0]        act_q, hs_q, vs_q;
  logic              fetch_q;
  logic [DATA_W-1:0] pix_q;

  // One RAM read per scaled block, on its leftmost screen pixel.
  assign dfetch    = disp_active_i && (xcol_i[SCALE_SHIFT-1:0] == '0);
  assign disp_addr = ADDR_W'(32'(yrow_i >> SCALE_SHIFT) * 32'(FB_W) + 32'(xcol_i >> SCALE_SHIFT));
  assign clr_start = (state == IDLE) && clr_i;
  assign clr_gnt   = (state == CLEAR) && !dfetch;
  assign wr_gnt    = (state == IDLE) && buf_full && !dfetch;
  assign busy_o    = (state == CLEAR);

  vga_fb_wbuf #(.FB_W(FB_W), .FB_H(FB_H), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wbuf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_x_i     (wr_x_i),
    .wr_y_i     (wr_y_i),
    .wr_data_i  (wr_data_i),
    .block_i    (busy_o),
    .flush_i    (clr_start),
    .drain_i    (wr_gnt),
    .full_o     (buf_full),
    .addr_o     (buf_addr),
    .data_o     (buf_data),
    .drop_clr_i (drop_clr_i),
    .drop_o     (drop_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      clr_col <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (clr_start) clr_col <= clr_color_i;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (clr_i) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        if (clr_gnt) begin
          if (cnt == ADDR_W'(FB_CNT - 1)) state_nx = IDLE;
          else                            cnt_nx   = cnt + ADDR_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (dfetch) begin
      mem_en_o   = 1'b1;
      mem_addr_o = disp_addr;
    end else if (state == CLEAR) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = cnt;
      mem_wdata_o = clr_col;
    end else if (buf_full) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = buf_addr;
      mem_wdata_o = buf_data;
    end
  end

  // Syncs and the active flag ride the same two-stage pipe as the RAM read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q   <= 2'b00;
      hs_q    <= 2'b11;
      vs_q    <= 2'b11;
      fetch_q <= 1'b0;
      pix_q   <= '0;
    end else begin
      act_q   <= {act_q[0], disp_active_i};
      hs_q    <= {hs_q[0], hsync_i};
      vs_q    <= {vs_q[0], vsync_i};
      fetch_q <= dfetch;
      if (fetch_q) pix_q <= mem_rdata_i;
    end
  end

  assign hsync_o = hs_q[1];
  assign vsync_o = vs_q[1];
  assign color_o = act_q[1] ? pix_q : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - randomized self-checking bench for vga_fb_arbiter against a framebuffer model
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_active = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [9:0]  xcol = '0, yrow = '0;
  logic        hsync_o, vsync_o, wr_ready, busy, drop;
  logic [11:0] color;
  logic        wr_valid = 1'b0, clr = 1'b0, drop_clr = 1'b0;
  logic [7:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [11:0] wr_data = '0, clr_color = '0;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata, mem_rdata = '0;

  logic [11:0] ram    [N];
  logic [11:0] ref_fb [N];
  int n_vec = 0, n_err = 0;

  always #20 clk = ~clk;

  vga_fb_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .disp_active_i(disp_active), .xcol_i(xcol), .yrow_i(yrow),
    .hsync_i(hsync), .vsync_i(vsync), .hsync_o(hsync_o), .vsync_o(vsync_o), .color_o(color),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_data_i(wr_data),
    .clr_i(clr), .clr_color_i(clr_color), .busy_o(busy), .drop_o(drop), .drop_clr_i(drop_clr),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // 640x480 timing source: 800 clocks per line, 525 lines per frame.
  int tx = 0, ty = 0;
  bit run = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    xcol = 10'(tx);
    yrow = 10'(ty);
    disp_active = run && tx < 640 && ty < 480;
    hsync = !(run && tx >= 656 && tx < 752);
    vsync = !(run && ty >= 490 && ty < 492);
    if (run) begin
      tx++;
      if (tx == 800) begin
        tx = 0;
        ty = (ty == 524) ? 0 : ty + 1;
      end
    end
  end

  // Single-port synchronous RAM seen by the DUT.
  logic        r_en, r_we;
  logic [14:0] r_a;
  logic [11:0] r_d;
  initial forever begin
    @(negedge clk);
    r_en = mem_en; r_we = mem_we; r_a = mem_addr; r_d = mem_wdata;
    @(posedge clk); #1;
    if (r_en && int'(r_a) < N) begin
      if (r_we) ram[r_a] = r_d;
      else      mem_rdata = ram[r_a];
    end
  end

  // Reference model: expected outputs from the timing inputs two clocks earlier and from
  // the framebuffer picture implied by accepted writes and clears.
  typedef struct { bit act; bit hs; bit vs; int x; int y; } tim_t;
  tim_t p1, p2, cur, idle_t;
  bit   chk_disp = 1'b0, clearing = 1'b0, drop_exp = 1'b0, fetch_now, oor;
  int   ccnt = 0;
  logic [11:0] ccol = '0;

  initial begin
    idle_t.act = 0; idle_t.hs = 1; idle_t.vs = 1; idle_t.x = 0; idle_t.y = 0;
    p1 = idle_t; p2 = idle_t;
    forever begin
      @(negedge clk);
      cur.act = disp_active; cur.hs = hsync; cur.vs = vsync; cur.x = int'(xcol); cur.y = int'(yrow);
      if (!rst_n) begin
        p1 = idle_t; p2 = idle_t; clearing = 0; drop_exp = 0; ccnt = 0;
      end else begin
        check("hsync_o", 32'(hsync_o), 32'(p2.hs));
        check("vsync_o", 32'(vsync_o), 32'(p2.vs));
        if (chk_disp)
          check("color_o", 32'(color), p2.act ? 32'(ref_fb[(p2.y >> 2) * W + (p2.x >> 2)]) : 32'd0);
        check("busy_o", 32'(busy), 32'(clearing));
        check("drop_o", 32'(drop), 32'(drop_exp));
        if (clearing) check("ready_in_clear", 32'(wr_ready), 32'd0);
        fetch_now = cur.act && (cur.x % 4 == 0);
        if (fetch_now)
          check("disp_rd", 32'({mem_en, mem_we, mem_addr}),
                32'({1'b1, 1'b0, 15'((cur.y >> 2) * W + (cur.x >> 2))}));
        else if (clearing)
          check("clr_wr", 32'({mem_en, mem_we, mem_addr, mem_wdata}),
                32'({1'b1, 1'b1, 15'(ccnt), ccol}));
        oor = (int'(wr_x) >= W) || (int'(wr_y) >= H);
        if (wr_valid && wr_ready) begin
          if (oor) drop_exp = 1;
          else     ref_fb[int'(wr_y) * W + int'(wr_x)] = wr_data;
        end
        if (drop_clr && !(wr_valid && wr_ready && oor)) drop_exp = 0;
        if (clearing) begin
          if (!fetch_now) begin
            ccnt++;
            if (ccnt == N) clearing = 0;
          end
        end else if (clr) begin
          clearing = 1; ccnt = 0; ccol = clr_color;
          foreach (ref_fb[i]) ref_fb[i] = ccol;
        end
        p2 = p1; p1 = cur;
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic ram_compare(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== ref_fb[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic wait_active_x(input int xv, output bit ok);
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #2;
      if (disp_active && int'(xcol) == xv) ok = 1;
    end
    if (!ok) check("timeout_active_x", 32'd0, 32'd1);
  endtask

  task automatic wait_blank();
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (int'(xcol) == 700) ok = 1;
    end
    if (!ok) check("timeout_blank", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int cyc;
    for (int i = 0; i < N; i++) begin
      ram[i] = 12'($urandom);
      ref_fb[i] = ram[i];
    end
    ram[0] = 12'hF00; ref_fb[0] = 12'hF00;
    ram[1] = 12'h0F0; ref_fb[1] = 12'h0F0;

    // Reset held low with the timing source running mid-frame.
    tx = 300; ty = 100; run = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_color", 32'(color), 32'd0);
    check("rst_hsync", 32'(hsync_o), 32'd1);
    check("rst_vsync", 32'(vsync_o), 32'd1);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    @(posedge clk); #2; run = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    repeat (3) @(posedge clk);

    // Row 0 scan: F00 then 0F0, each for 4 pixels, two clocks after xcol=0.
    @(negedge clk); tx = 0; ty = 0; run = 1; chk_disp = 1;
    @(negedge clk);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check("row0_color", 32'(color), (k < 4) ? 32'h00F00 : 32'h000F0);
      check("row0_hsync", 32'(hsync_o), 32'd1);
      @(negedge clk);
    end
    repeat (3200) @(negedge clk);

    // Write stalled by the dfetch at xcol=20, granted the next cycle at address 485.
    wait_active_x(19, ok);
    if (ok) begin
      wr_valid = 1; wr_x = 8'd5; wr_y = 7'd3; wr_data = 12'h00F;
      @(negedge clk); check("wr_ready_x19", 32'(wr_ready), 32'd1);
      @(posedge clk); #2; wr_valid = 0;
      @(negedge clk);
      check("stall_we", 32'(mem_we), 32'd0);
      check("stall_ready", 32'(wr_ready), 32'd0);
      @(negedge clk);
      check("wr_gnt", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 15'd485, 12'h00F}));
    end

    // Out-of-range write: accepted, not stored, sticky drop until drop_clr_i.
    @(posedge clk); #2; wr_valid = 1; wr_x = 8'd160; wr_y = 7'd0; wr_data = 12'h777;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (wr_ready) ok = 1;
      else begin @(posedge clk); #2; end
    end
    check("drop_handshake", 32'(ok), 32'd1);
    @(posedge clk); #2; wr_valid = 0;
    @(negedge clk);
    check("drop_set", 32'(drop), 32'd1);
    check("drop_nowr_a", 32'(mem_we), 32'd0);
    @(negedge clk); check("drop_nowr_b", 32'(mem_we), 32'd0);
    @(posedge clk); #2; drop_clr = 1;
    @(posedge clk); #2; drop_clr = 0;
    @(negedge clk); check("drop_cleared", 32'(drop), 32'd0);

    // Random writes, including out-of-range ones and drop clears, under live timing.
    chk_disp = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      wr_valid = 1'($urandom);
      wr_x = 8'($urandom_range(0, 170));
      wr_y = 7'($urandom_range(0, 127));
      wr_data = 12'($urandom);
      drop_clr = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk); #2; wr_valid = 0; drop_clr = 0;
    repeat (20) @(posedge clk);
    ram_compare("ram_after_writes");
    wait_blank(); chk_disp = 1;
    repeat (1600) @(negedge clk);

    // Clear while the buffer holds a write during active video; a second clr_i is ignored.
    wait_active_x(43, ok);
    if (ok) begin
      chk_disp = 0;
      wr_valid = 1; wr_x = 8'd7; wr_y = 7'd7; wr_data = 12'h123;
      @(posedge clk); #2; wr_valid = 0; clr = 1; clr_color = 12'hABC;
      @(posedge clk); #2; clr = 0;
      repeat (100) @(posedge clk);
      #2 clr = 1; clr_color = 12'h555;
      @(posedge clk); #2; clr = 0;
      cyc = 101;
      ok = 0;
      for (int i = 0; i < 40000 && !ok; i++) begin
        @(negedge clk);
        if (busy) cyc++; else ok = 1;
      end
      check("clr_done", 32'(ok), 32'd1);
      check("clr_len_ge_fbsize", 32'(cyc >= N), 32'd1);
      check("ready_after_clr", 32'(wr_ready), 32'd1);
      repeat (10) @(posedge clk);
      check("clr_buffered_discarded", 32'(ram[7 * W + 7]), 32'hABC);
      ram_compare("ram_after_clear");
      wait_blank(); chk_disp = 1;
      repeat (900) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
